ncc_window_scheduler: RTL

Sequencing controller for the NCC window memory: 16 row BRAMs, each one byte wide and 80 entries deep. It loads a 16x80 search window from the 8-bit PCI pixel stream into the row BRAMs in row-major order. It then sweeps the 16x16 descriptor horizontally across all 65 offsets, issuing one column read (all 16 rows in parallel) per cycle to the correlator. It sits between the PCI byte interface and the correlation/accumulate datapath, alongside the descriptor shift-register loader.

---
 rtl/ncc_window_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ncc_window_scheduler.sv
// NCC window scheduler: loads a ROWS x COLS search window into the row BRAMs, then sweeps
// the DESC_W-wide descriptor across every offset. Optional stall counter: NCC_SCHED_PERF_EN.
module ncc_window_scheduler #(
  parameter int ROWS   = 16,
  parameter int COLS   = 80,
  parameter int DESC_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_pix_valid,
  input  logic [7:0]               i_pix_data,
  output logic                     o_pix_ready,
  output logic                     o_wr_en,
  output logic [ROWS-1:0]          o_wr_row,
  output logic [$clog2(COLS)-1:0]  o_wr_addr,
  output logic [7:0]               o_wr_data,
  output logic                     o_rd_en,
  output logic [$clog2(COLS)-1:0]  o_rd_addr,
  input  logic                     i_acc_ready,
  output logic                     o_col_valid,
  output logic                     o_col_first,
  output logic                     o_col_last,
  output logic [$clog2(COLS)-1:0]  o_col_pos,
  output logic                     o_busy,
  output logic                     o_done
`ifdef NCC_SCHED_PERF_EN
  ,
  output logic [15:0]              o_stall_cycles
`endif
);

  localparam int AW   = $clog2(COLS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (DESC_W > 1) ? $clog2(DESC_W) : 1;
  localparam int XMAX = COLS - DESC_W;

  generate
    if (DESC_W > COLS || ROWS < 1 || RD_LAT < 1 || RD_LAT > 3) begin : g_param_check
      $error("ncc_window_scheduler: invalid DESC_W/COLS/ROWS/RD_LAT");
    end
  endgenerate

  // IDLE wait start | LOAD write pixel bytes | SWEEP issue column reads | DRAIN flush read pipe
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [RW-1:0] r_row;
  logic [AW-1:0] r_col, r_x;
  logic [CW-1:0] r_c;
  logic [1:0]    r_drain;
  logic          w_start_acc, w_pix_acc, w_rd;
  logic          w_col_wrap, w_load_last, w_c_wrap, w_sweep_last, w_drain_last;

  assign w_start_acc  = i_start && (r_state == S_IDLE);
  assign w_pix_acc    = i_pix_valid && (r_state == S_LOAD);
  assign w_rd         = i_acc_ready && (r_state == S_SWEEP);
  assign w_col_wrap   = (r_col == AW'(COLS - 1));
  assign w_load_last  = w_col_wrap && (r_row == RW'(ROWS - 1));
  assign w_c_wrap     = (r_c == CW'(DESC_W - 1));
  assign w_sweep_last = w_c_wrap && (r_x == AW'(XMAX));
  assign w_drain_last = (r_drain == 2'(RD_LAT - 1));
  assign o_pix_ready  = (r_state == S_LOAD);
  assign o_rd_addr    = r_x + AW'(r_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_rd_en     = 1'b0;
    o_done      = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_pix_acc && w_load_last) w_state_nxt = S_SWEEP;
      S_SWEEP: begin
        o_rd_en = i_acc_ready;
        if (i_acc_ready && w_sweep_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_drain_last) begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_x     <= '0;
      r_c     <= '0;
      r_drain <= '0;
    end else begin
      if (w_start_acc) begin
        r_row <= '0;
        r_col <= '0;
        r_x   <= '0;
        r_c   <= '0;
      end
      if (w_pix_acc) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_rd) begin
        if (w_c_wrap) begin
          r_c <= '0;
          r_x <= r_x + 1'b1;
        end else begin
          r_c <= r_c + 1'b1;
        end
      end
      r_drain <= (r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
    end
  end

  logic [ROWS-1:0] r_wr_row;
  logic [AW-1:0]   r_wr_addr;
  logic [7:0]      r_wr_data;
  logic            r_wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_row  <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pix_acc;
      if (w_pix_acc) begin
        r_wr_row  <= ROWS'(1) << r_row;
        r_wr_addr <= r_col;
        r_wr_data <= i_pix_data;
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_row  = r_wr_row;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

  // Column metadata rides alongside rd_en so it lines up with the BRAM output
  logic [RD_LAT-1:0] r_pv, r_pf, r_pl;
  logic [AW-1:0]     r_pp [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_pf <= '0;
      r_pl <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pp[i] <= '0;
    end else begin
      r_pv[0] <= w_rd;
      r_pf[0] <= w_rd && (r_c == '0);
      r_pl[0] <= w_rd && w_c_wrap;
      r_pp[0] <= w_rd ? r_x : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pf[i] <= r_pf[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pp[i] <= r_pp[i-1];
      end
    end
  end

  assign o_col_valid = r_pv[RD_LAT-1];
  assign o_col_first = r_pf[RD_LAT-1];
  assign o_col_last  = r_pl[RD_LAT-1];
  assign o_col_pos   = r_pp[RD_LAT-1];

`ifdef NCC_SCHED_PERF_EN
  logic [15:0] r_stall;
  logic        w_stall;

  assign w_stall = ((r_state == S_SWEEP) && !i_acc_ready) ||
                   ((r_state == S_LOAD) && !i_pix_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_stall <= '0;
    else if (w_start_acc)                     r_stall <= '0;
    else if (w_stall && r_stall != 16'hFFFF)  r_stall <= r_stall + 16'd1;
  end

  assign o_stall_cycles = r_stall;
`endif

endmodule
